// File: rtl/addrgen_pkg.sv
// rtl/addrgen_pkg.sv - shared types and helpers for the scratchpad address generators
// Contents: FSM state encoding, default widths, encoded-word field positions,
// series length helper (N = 1 << LEN).
package addrgen_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int RUN_W_DEF  = 5;
    localparam int LEN_W      = 3;
    // Wide enough for N-1 with N up to 128.
    localparam int CNT_W      = 8;

    // Encoded word = {run, value}; value sits at the bottom.
    localparam int VAL_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    function automatic int run_lsb(input int data_w);
        return VAL_LSB + data_w;
    endfunction

    function automatic logic [CNT_W-1:0] series_len(input logic [LEN_W-1:0] len);
        return CNT_W'(1) << len;
    endfunction

endpackage

// File: rtl/addrwr_if.sv
// rtl/addrwr_if.sv - input word stream plus scratchpad write bus
// DIN/DIN_VALID/DIN_READY : encoded or raw word stream into the generator
// ADDR/WDATA/WE           : registered memory write port out of the generator
// master = producer / memory side, slave = addrwr.
interface addrwr_if
    import addrgen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RUN_W  = RUN_W_DEF
) ();

    logic [DATA_W+RUN_W-1:0] DIN;
    logic                    DIN_VALID;
    logic                    DIN_READY;
    logic [ADDR_W-1:0]       ADDR;
    logic [DATA_W-1:0]       WDATA;
    logic                    WE;

    modport master (
        output DIN, DIN_VALID,
        input  DIN_READY, ADDR, WDATA, WE
    );

    modport slave (
        input  DIN, DIN_VALID,
        output DIN_READY, ADDR, WDATA, WE
    );

endinterface

// File: rtl/addr_cnt.sv
// rtl/addr_cnt.sv - loadable address pointer plus down-counter with terminal-count flag
// load_i     : load ptr_init_i / cnt_init_i (wins over step_i)
// step_i     : ptr += stride_i, cnt -= 1
// tc_o       : counter is at zero (the current step is the final one)
module addr_cnt #(
    parameter int PTR_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [PTR_W-1:0] ptr_init_i,
    input  logic [CNT_W-1:0] cnt_init_i,
    input  logic             step_i,
    input  logic [PTR_W-1:0] stride_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic             tc_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            ptr_q <= ptr_init_i;
            cnt_q <= cnt_init_i;
        end else if (step_i) begin
            ptr_q <= ptr_q + stride_i;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign ptr_o = ptr_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/addrwr.sv
// rtl/addrwr.sv - write-side scratchpad address generator with optional RLC decode
// clk, rst (async, active low); en start pulse; ENCODE/LEN/BASE latched at start
// bus (addrwr_if.slave): DIN stream in, ADDR/WDATA/WE write port out
// BUSY series in progress; DONE pulse with last WE; OVF sticky run overflow
// Optional macro ADDRWR_STRIDE_EN adds STRIDE input (pointer increment).
module addrwr
    import addrgen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RUN_W  = RUN_W_DEF,
    parameter int IN_W   = DATA_W + RUN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ENCODE,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [ADDR_W-1:0] BASE,
`ifdef ADDRWR_STRIDE_EN
    input  logic [ADDR_W-1:0] STRIDE,
`endif
    addrwr_if.slave           bus,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF
);

    localparam int RUN_LSB = run_lsb(DATA_W);

    state_e            state_q;
    logic              enc_q;
    logic [DATA_W-1:0] hold_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              done_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] step;

`ifdef ADDRWR_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    logic [IN_W-1:0]   din;
    logic [RUN_W-1:0]  run;
    logic [DATA_W-1:0] val;
    assign din = bus.DIN;
    assign run = din[RUN_LSB +: RUN_W];
    assign val = din[VAL_LSB +: DATA_W];

    logic              run_nz, start, hs, in_zero, wr, zload, zstep, drop;
    logic              series_tc, zero_tc;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] wdata_d;
    logic              zero_ptr_unused;

    assign run_nz  = enc_q && (run != '0);
    // A start is refused in the DONE cycle so en must be re-asserted after it.
    assign start   = (state_q == ST_IDLE) && en && !done_q;
    assign hs      = (state_q == ST_XFER) && bus.DIN_VALID;
    assign in_zero = (state_q == ST_ZERO);
    // The first zero of a run is written on the accepting cycle itself,
    // so a word with run R costs exactly R+1 write cycles.
    assign wr      = hs || in_zero;
    assign zload   = hs && run_nz;
    assign zstep   = in_zero && !zero_tc;
    // Series ends while the held value is still pending: value is lost.
    assign drop    = series_tc && (zload || zstep);

    always_comb begin
        wdata_d = '0;
        if (hs && !run_nz) begin
            wdata_d = val;
        end else if (in_zero && zero_tc) begin
            wdata_d = hold_q;
        end
    end

    // Counts hold "writes left minus one" so tc marks the final write.
    addr_cnt #(.PTR_W(ADDR_W), .CNT_W(CNT_W)) u_series (
        .clk        (clk),
        .rst        (rst),
        .load_i     (start),
        .ptr_init_i (BASE),
        .cnt_init_i (series_len(LEN) - CNT_W'(1)),
        .step_i     (wr),
        .stride_i   (step),
        .ptr_o      (ptr),
        .tc_o       (series_tc)
    );

    addr_cnt #(.PTR_W(1), .CNT_W(RUN_W)) u_zero (
        .clk        (clk),
        .rst        (rst),
        .load_i     (zload),
        .ptr_init_i (1'b0),
        .cnt_init_i (run - RUN_W'(1)),
        .step_i     (zstep),
        .stride_i   (1'b0),
        .ptr_o      (zero_ptr_unused),
        .tc_o       (zero_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            enc_q    <= 1'b0;
            hold_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ADDRWR_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            we_q   <= wr;
            done_q <= wr && series_tc;
            if (wr) begin
                addr_q  <= ptr;
                wdata_q <= wdata_d;
            end
            if (zload) begin
                hold_q <= val;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        enc_q   <= ENCODE;
                        ovf_q   <= 1'b0;
`ifdef ADDRWR_STRIDE_EN
                        stride_q <= STRIDE;
`endif
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (hs) begin
                        if (series_tc) begin
                            state_q <= ST_IDLE;
                        end else if (run_nz) begin
                            state_q <= ST_ZERO;
                        end
                    end
                end
                ST_ZERO: begin
                    if (series_tc) begin
                        state_q <= ST_IDLE;
                    end else if (zero_tc) begin
                        state_q <= ST_XFER;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.DIN_READY = (state_q == ST_XFER);
    assign bus.ADDR      = addr_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WE        = we_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = done_q;
    assign OVF           = ovf_q;

endmodule

// File: tb/tb_addrwr.sv
// tb/tb_addrwr.sv - self-checking bench for addrwr against a word-expansion reference model
module tb_addrwr;

    logic       clk = 1'b0;
    logic       rst, en, ENCODE;
    logic [2:0] LEN;
    logic [7:0] BASE, STRIDE;
    logic       BUSY, DONE, OVF;

    addrwr_if bus ();

    addrwr dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ENCODE (ENCODE),
        .LEN    (LEN),
        .BASE   (BASE),
`ifdef ADDRWR_STRIDE_EN
        .STRIDE (STRIDE),
`endif
        .bus    (bus),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .OVF    (OVF)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stray_done = 0;

    logic [7:0]  w_addr[$];
    logic [15:0] w_data[$];
    logic        w_done[$];
    int          w_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.WE === 1'b1) begin
            w_addr.push_back(bus.ADDR);
            w_data.push_back(bus.WDATA);
            w_done.push_back(DONE);
            w_cyc.push_back(cyc);
        end else if (DONE === 1'b1) begin
            stray_done++;
        end
    end

    logic [20:0] words[$];
    logic [15:0] exp_d[$];
    bit          exp_ovf;
    int          exp_used;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expand each word into its writes (run zeros then value in encoded mode),
    // stop consuming words once N writes exist, then cut to N.
    task automatic build_model(input bit enc, input int n);
        exp_d.delete();
        exp_used = 0;
        for (int i = 0; i < words.size() && exp_d.size() < n; i++) begin
            if (enc) begin
                for (int z = 0; z < int'(words[i][20:16]); z++) exp_d.push_back(16'h0);
            end
            exp_d.push_back(words[i][15:0]);
            exp_used++;
        end
        exp_ovf = (exp_d.size() > n);
        while (exp_d.size() > n) void'(exp_d.pop_back());
    endtask

    task automatic run_series(input bit enc, input int len, input logic [7:0] base,
                              input logic [7:0] stride, input int gap_pct,
                              input bit mid_en, input string tag);
        int         n;
        int         idx;
        int         guard;
        bit         acc;
        logic [7:0] eff;
        logic [7:0] ea;
        n = 1 << len;
        idx = 0;
        guard = 0;
`ifdef ADDRWR_STRIDE_EN
        eff = stride;
`else
        eff = 8'd1;
`endif
        build_model(enc, n);
        w_addr.delete(); w_data.delete(); w_done.delete(); w_cyc.delete();
        stray_done = 0;
        @(negedge clk);
        ENCODE = enc; LEN = 3'(len); BASE = base; STRIDE = stride; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        ENCODE = 1'($urandom); LEN = 3'($urandom); BASE = 8'($urandom); STRIDE = 8'($urandom);
        chk({tag, "/busy_start"}, BUSY, 1);
        chk({tag, "/ovf_clr"}, OVF, 0);
        while (BUSY === 1'b1 && guard < 4000) begin
            en = mid_en && (guard == 2);
            if (idx < words.size()) begin
                bus.DIN_VALID = ($urandom_range(99) >= gap_pct);
                bus.DIN = words[idx];
            end else begin
                bus.DIN_VALID = 1'b0;
            end
            acc = bus.DIN_VALID && bus.DIN_READY;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        bus.DIN_VALID = 1'b0;
        chk({tag, "/timeout"}, guard < 4000, 1);
        chk({tag, "/done_pulse"}, DONE, 1);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk({tag, "/en_at_done_busy"}, BUSY, 0);
        chk({tag, "/done_clr"}, DONE, 0);
        chk({tag, "/ready_idle"}, bus.DIN_READY, 0);
        chk({tag, "/nwrites"}, w_addr.size(), n);
        for (int i = 0; i < w_addr.size() && i < n; i++) begin
            ea = 8'(int'(base) + i * int'(eff));
            chk({tag, "/addr"}, w_addr[i], ea);
            chk({tag, "/data"}, w_data[i], exp_d[i]);
            chk({tag, "/done_at"}, w_done[i], (i == n - 1));
            if (!enc && gap_pct == 0) chk({tag, "/back2back"}, w_cyc[i] - w_cyc[0], i);
        end
        chk({tag, "/ovf"}, OVF, exp_ovf);
        chk({tag, "/words_used"}, idx, exp_used);
        chk({tag, "/stray_done"}, stray_done, 0);
    endtask

    initial begin
        int n;
        int tot;
        int r;
        bit enc;
        rst = 1'b0; en = 1'b0; ENCODE = 1'b0; LEN = 3'd0; BASE = 8'd0; STRIDE = 8'd1;
        bus.DIN = '0; bus.DIN_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/we", bus.WE, 0);
        chk("rst/busy", BUSY, 0);
        chk("rst/done", DONE, 0);
        chk("rst/ovf", OVF, 0);
        chk("rst/ready", bus.DIN_READY, 0);
        chk("rst/addr", bus.ADDR, 0);
        chk("rst/wdata", bus.WDATA, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle/busy", BUSY, 0);

        words = '{21'h000001, 21'h000002, 21'h000003, 21'h000004};
        run_series(1'b0, 2, 8'h10, 8'd1, 0, 1'b0, "raw");

        words = '{{5'd2, 16'd7}, {5'd0, 16'd5}, {5'd3, 16'd9}};
        run_series(1'b1, 3, 8'h20, 8'd1, 0, 1'b0, "enc");

        words = '{{5'd4, 16'd6}};
        run_series(1'b1, 1, 8'h30, 8'd1, 0, 1'b0, "ovf");

        words = '{21'h0000AA, 21'h0000BB, 21'h0000CC, 21'h0000DD};
        run_series(1'b0, 2, 8'hFE, 8'd1, 0, 1'b0, "wrap");

        words.delete();
        for (int i = 0; i < 8; i++) words.push_back(21'($urandom));
        run_series(1'b0, 3, 8'h50, 8'd1, 50, 1'b1, "bp");

`ifdef ADDRWR_STRIDE_EN
        words = '{21'h000011, 21'h000022, 21'h000033, 21'h000044};
        run_series(1'b0, 2, 8'h00, 8'd3, 0, 1'b0, "stride");
`endif

        @(negedge clk);
        ENCODE = 1'b1; LEN = 3'd7; BASE = 8'h40; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        bus.DIN = {5'd20, 16'h1234}; bus.DIN_VALID = 1'b1;
        @(negedge clk);
        bus.DIN_VALID = 1'b0;
        @(negedge clk);
        chk("rz/ready_low", bus.DIN_READY, 0);
        chk("rz/we", bus.WE, 1);
        chk("rz/wdata", bus.WDATA, 0);
        rst = 1'b0;
        #1;
        chk("rz/we_async", bus.WE, 0);
        chk("rz/busy_async", BUSY, 0);
        chk("rz/done_async", DONE, 0);
        chk("rz/ready_async", bus.DIN_READY, 0);
        w_addr.delete(); w_data.delete(); w_done.delete(); w_cyc.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.DIN = {5'd0, 16'h5555}; bus.DIN_VALID = 1'b1;
        repeat (6) @(negedge clk);
        chk("rz/no_write_after", w_addr.size(), 0);
        chk("rz/idle_after", BUSY, 0);
        bus.DIN_VALID = 1'b0;

        for (int s = 0; s < 20; s++) begin
            enc = 1'($urandom);
            r = $urandom_range(7);
            n = 1 << r;
            words.delete();
            tot = 0;
            while (tot < n) begin
                int run;
                run = ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(3);
                words.push_back({5'(run), 16'($urandom)});
                tot += enc ? run + 1 : 1;
            end
            run_series(enc, r, 8'($urandom), 8'($urandom), (s % 3) * 30, 1'(s % 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
